// File: rtl/move_cmd_exec.sv
// Command executor for calibrate/move commands: turns to the requested
// heading, ramps forward speed up, counts centre-line crossings and ramps down.
module move_cmd_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  input  logic        cal_done,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        strt_cal,
  output logic [11:0] desired_heading,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare
);

  typedef enum logic [2:0] {IDLE, CAL, TURN, RAMP_UP, RAMP_DN} state_t;

  localparam logic [3:0]  OP_CAL         = 4'h0;
  localparam logic [3:0]  OP_MOVE        = 4'h2;
  localparam logic [3:0]  OP_MOVE_FANF   = 4'h3;
  localparam logic [9:0]  RAMP_UP_STEP   = 10'h020;
  localparam logic [9:0]  RAMP_DN_STEP   = 10'h040;
  localparam logic [9:0]  FRWRD_MAX      = 10'h300;
  localparam logic [11:0] HEADING_TOL    = 12'd44;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg, op_next;
  logic [3:0]  squares_reg, squares_next;
  logic [11:0] dh_reg, dh_next;
  logic [9:0]  frwrd_reg, frwrd_next;
  logic [4:0]  line_cnt_reg, line_cnt_next;
  logic [1:0]  cntr_sync_reg;
  logic        cntr_prev_reg;
  logic        clr_reg, clr_next;
  logic        resp_reg, resp_next;
  logic        cal_reg, cal_next;
  logic        fan_reg, fan_next;
  logic        pend_reg, pend_next;

  logic [11:0] err;
  logic [11:0] err_abs;
  logic        heading_ok;
  logic        lines_done;
  logic        cntr_rise;

  assign err        = heading - dh_reg;
  assign err_abs    = err[11] ? (12'd0 - err) : err;
  assign heading_ok = (err_abs < HEADING_TOL);
  assign lines_done = (line_cnt_reg == {squares_reg, 1'b0});
  assign cntr_rise  = cntr_sync_reg[1] & ~cntr_prev_reg;

  assign moving          = (state_reg == TURN) || (state_reg == RAMP_UP) || (state_reg == RAMP_DN);
  assign clr_cmd_rdy     = clr_reg;
  assign send_resp       = resp_reg;
  assign strt_cal        = cal_reg;
  assign fanfare         = fan_reg;
  assign desired_heading = dh_reg;
  assign frwrd           = frwrd_reg;

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    squares_next  = squares_reg;
    dh_next       = dh_reg;
    frwrd_next    = frwrd_reg;
    line_cnt_next = line_cnt_reg;
    clr_next      = 1'b0;
    resp_next     = 1'b0;
    cal_next      = 1'b0;
    fan_next      = 1'b0;
    pend_next     = 1'b0;

    if (moving && cntr_rise) begin
      line_cnt_next = line_cnt_reg + 5'd1;
    end

    unique case (state_reg)
      IDLE: begin
        if (pend_reg) begin
          resp_next = 1'b1;
        end
        // cmd_rdy is still high while our accept pulse is out; don't take it twice
        if (cmd_rdy && !clr_reg) begin
          clr_next      = 1'b1;
          op_next       = cmd[15:12];
          squares_next  = cmd[3:0];
          line_cnt_next = 5'd0;
          frwrd_next    = 10'd0;
          case (cmd[15:12])
            OP_CAL: begin
              cal_next   = 1'b1;
              state_next = CAL;
            end
            OP_MOVE, OP_MOVE_FANF: begin
              dh_next    = (cmd[11:4] == 8'd0) ? 12'h000 : {cmd[11:4], 4'hF};
              state_next = TURN;
            end
            default: pend_next = 1'b1;
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_next  = 1'b1;
          state_next = IDLE;
        end
      end
      TURN: begin
        frwrd_next = 10'd0;
        if (lines_done) begin
          state_next = RAMP_DN;
        end else if (heading_rdy && heading_ok) begin
          state_next = RAMP_UP;
        end
      end
      RAMP_UP: begin
        // line match wins over a coincident speed step: speed freezes that cycle
        if (lines_done) begin
          state_next = RAMP_DN;
        end else if (heading_rdy) begin
          frwrd_next = (frwrd_reg >= FRWRD_MAX - RAMP_UP_STEP) ? FRWRD_MAX
                                                               : frwrd_reg + RAMP_UP_STEP;
        end
      end
      RAMP_DN: begin
        if (frwrd_reg == 10'd0) begin
          resp_next  = 1'b1;
          fan_next   = (op_reg == OP_MOVE_FANF);
          state_next = IDLE;
        end else if (heading_rdy) begin
          frwrd_next = (frwrd_reg > RAMP_DN_STEP) ? frwrd_reg - RAMP_DN_STEP : 10'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= 4'd0;
      squares_reg   <= 4'd0;
      dh_reg        <= 12'h000;
      frwrd_reg     <= 10'd0;
      line_cnt_reg  <= 5'd0;
      cntr_sync_reg <= 2'b00;
      cntr_prev_reg <= 1'b0;
      clr_reg       <= 1'b0;
      resp_reg      <= 1'b0;
      cal_reg       <= 1'b0;
      fan_reg       <= 1'b0;
      pend_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      squares_reg   <= squares_next;
      dh_reg        <= dh_next;
      frwrd_reg     <= frwrd_next;
      line_cnt_reg  <= line_cnt_next;
      cntr_sync_reg <= {cntr_sync_reg[0], cntrIR};
      cntr_prev_reg <= cntr_sync_reg[1];
      clr_reg       <= clr_next;
      resp_reg      <= resp_next;
      cal_reg       <= cal_next;
      fan_reg       <= fan_next;
      pend_reg      <= pend_next;
    end
  end

endmodule
